// File: rtl/regfile_pkg.sv
// Shared types for the ID-stage register-file write port.
// Declarations only; no logic.
package regfile_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int NUM_REGS   = 32;
    localparam int DATA_W     = 32;

    localparam logic [REG_ADDR_W-1:0] LAST_REG = REG_ADDR_W'(NUM_REGS - 1);

    typedef enum logic {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } wport_state_t;

    typedef struct packed {
        logic [REG_ADDR_W-1:0] rd;
        logic [DATA_W-1:0]     data;
    } wreq_t;

endpackage

// File: rtl/regfile_wport_arbiter_if.sv
// Bundle of the two writeback request channels and the register-file write port.
// slave = arbiter view, master = requester / register-file side.
interface regfile_wport_arbiter_if
    import regfile_pkg::*;
#(
    parameter int WIDTH = DATA_W
);

    logic                  a_valid;
    logic [REG_ADDR_W-1:0] a_rd;
    logic [WIDTH-1:0]      a_data;
    logic                  a_ready;

    logic                  b_valid;
    logic [REG_ADDR_W-1:0] b_rd;
    logic [WIDTH-1:0]      b_data;
    logic                  b_ready;

    logic [REG_ADDR_W-1:0] rf_rd_addr;
    logic [WIDTH-1:0]      rf_write_data;
    logic                  rf_regWrite;
    logic                  init_done;

    modport slave (
        input  a_valid, a_rd, a_data,
        output a_ready,
        input  b_valid, b_rd, b_data,
        output b_ready,
        output rf_rd_addr, rf_write_data, rf_regWrite, init_done
    );

    modport master (
        output a_valid, a_rd, a_data,
        input  a_ready,
        output b_valid, b_rd, b_data,
        input  b_ready,
        input  rf_rd_addr, rf_write_data, rf_regWrite, init_done
    );

endinterface

// File: rtl/regfile_clear_seq.sv
// Post-reset clear sequencer: walks x1..x31 once, then flags the write port live.
// Latency: one address per cycle, 31 cycles total; no backpressure (owns the port while clearing).
module regfile_clear_seq
    import regfile_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    output logic                  clr_vld,
    output logic [REG_ADDR_W-1:0] clr_addr,
    output logic                  init_done
);

    wport_state_t          state_q, state_d;
    logic [REG_ADDR_W-1:0] clear_cnt_q, clear_cnt_d;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= CLEAR;
            clear_cnt_q <= REG_ADDR_W'(1);
        end else begin
            state_q     <= state_d;
            clear_cnt_q <= clear_cnt_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        clear_cnt_d = clear_cnt_q;
        clr_vld     = 1'b0;
        case (state_q)
            CLEAR: begin
                clr_vld     = 1'b1;
                clear_cnt_d = clear_cnt_q + 1'b1;
                if (clear_cnt_q == LAST_REG) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                clear_cnt_d = clear_cnt_q;
            end
        endcase
    end

    assign clr_addr  = clear_cnt_q;
    assign init_done = (state_q == RUN);

endmodule

// File: rtl/regfile_wport_arbiter.sv
// Register-file write-port owner: clears x1..x31 after reset, then arbitrates A (ALU) over B (load/mul).
// Latency: accepted write shows on rf_* one cycle after the accepting edge; x0 writes keep rf_regWrite low.
// Backpressure: readies low while clearing; b_ready only when A idle (REGFILE_STARVE_GUARD_EN forces B after STARVE_LIMIT losses).
module regfile_wport_arbiter
    import regfile_pkg::*;
#(
    parameter int WIDTH = DATA_W
`ifdef REGFILE_STARVE_GUARD_EN
    ,
    parameter int STARVE_LIMIT = 4
`endif
) (
    input  logic                   clk,
    input  logic                   rst,
    regfile_wport_arbiter_if.slave wp
);

    logic                  clr_vld;
    logic [REG_ADDR_W-1:0] clr_addr;
    logic                  init_done;
    logic                  run;
    logic                  starve_force;
    logic                  a_acc;
    logic                  b_acc;

    wreq_t                 out_q, out_d;
    logic                  rf_we_q, rf_we_d;

    regfile_clear_seq u_clear_seq (
        .clk       (clk),
        .rst       (rst),
        .clr_vld   (clr_vld),
        .clr_addr  (clr_addr),
        .init_done (init_done)
    );

    assign run = init_done;

`ifdef REGFILE_STARVE_GUARD_EN
    localparam int                  STARVE_W   = $clog2(STARVE_LIMIT + 1);
    localparam logic [STARVE_W-1:0] STARVE_MAX = STARVE_W'(STARVE_LIMIT);

    logic [STARVE_W-1:0] starve_cnt_q, starve_cnt_d;

    assign starve_force = run && (starve_cnt_q == STARVE_MAX);

    always_comb begin
        starve_cnt_d = starve_cnt_q;
        if (b_acc) begin
            starve_cnt_d = '0;
        end else if (run && wp.a_valid && wp.b_valid && (starve_cnt_q != STARVE_MAX)) begin
            starve_cnt_d = starve_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            starve_cnt_q <= '0;
        end else begin
            starve_cnt_q <= starve_cnt_d;
        end
    end
`else
    assign starve_force = 1'b0;
`endif

    // A and B readies are mutually exclusive whenever A is pending, so at most one accept per edge.
    assign wp.a_ready = run && !starve_force;
    assign wp.b_ready = run && (starve_force || !wp.a_valid);

    assign a_acc = wp.a_valid && wp.a_ready;
    assign b_acc = wp.b_valid && wp.b_ready;

    always_comb begin
        out_d   = out_q;
        rf_we_d = 1'b0;
        if (clr_vld) begin
            out_d.rd   = clr_addr;
            out_d.data = '0;
            rf_we_d    = 1'b1;
        end else if (a_acc) begin
            out_d.rd   = wp.a_rd;
            out_d.data = DATA_W'(wp.a_data);
            rf_we_d    = (wp.a_rd != '0);
        end else if (b_acc) begin
            out_d.rd   = wp.b_rd;
            out_d.data = DATA_W'(wp.b_data);
            rf_we_d    = (wp.b_rd != '0);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_q   <= '0;
            rf_we_q <= 1'b0;
        end else begin
            out_q   <= out_d;
            rf_we_q <= rf_we_d;
        end
    end

    assign wp.rf_regWrite   = rf_we_q;
    assign wp.rf_rd_addr    = out_q.rd;
    assign wp.rf_write_data = WIDTH'(out_q.data);
    assign wp.init_done     = init_done;

endmodule

// File: tb/tb_regfile_wport_arbiter.sv
// Scoreboard bench for regfile_wport_arbiter: driver predicts writes from the arbitration rules,
// monitor pops one expected write per cycle that shows rf_regWrite.
module tb_regfile_wport_arbiter;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    regfile_wport_arbiter_if #(.WIDTH(32)) wp ();

    regfile_wport_arbiter #(.WIDTH(32)) dut (
        .clk (clk),
        .rst (rst),
        .wp  (wp)
    );

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;
    bit   a_hold;
    bit   b_hold;
    int   b_losses;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: every write the register file sees must be the next predicted one.
    always @(negedge clk) begin : monitor
        exp_t e;
        if (wp.rf_regWrite === 1'b1) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL rf_write_spurious: got addr=%0d data=%0h, expected no write (t=%0t)",
                         wp.rf_rd_addr, wp.rf_write_data, $time);
            end else begin
                e = exp_q.pop_front();
                chk("rf_rd_addr", 32'(wp.rf_rd_addr), 32'(e.rd));
                chk("rf_write_data", wp.rf_write_data, e.data);
            end
        end
    end

    // Reference arbitration: A wins unless B has lost STARVE_LIMIT times in a row (guard build only).
    task automatic settle_and_score();
        bit force_b;
        bit exp_ar;
        bit exp_br;
        bit a_acc;
        bit b_acc;
        #1;
        force_b = 1'b0;
`ifdef REGFILE_STARVE_GUARD_EN
        force_b = (b_losses == 4);
`endif
        exp_ar = !force_b;
        exp_br = force_b || !wp.a_valid;
        chk("a_ready", 32'(wp.a_ready), 32'(exp_ar));
        chk("b_ready", 32'(wp.b_ready), 32'(exp_br));
        a_acc = wp.a_valid && exp_ar;
        b_acc = wp.b_valid && exp_br;
        if (a_acc && wp.a_rd != 5'd0) exp_q.push_back('{wp.a_rd, wp.a_data});
        if (b_acc && wp.b_rd != 5'd0) exp_q.push_back('{wp.b_rd, wp.b_data});
        if (b_acc) b_losses = 0;
        else if (wp.a_valid && wp.b_valid && b_losses < 4) b_losses++;
        a_hold = wp.a_valid && !a_acc;
        b_hold = wp.b_valid && !b_acc;
    endtask

    task automatic assert_reset();
        #2;
        rst      = 1'b0;
        a_hold   = 1'b0;
        b_hold   = 1'b0;
        b_losses = 0;
        wp.a_valid = 1'b0;
        wp.b_valid = 1'b0;
        #1;
        chk("rst_regWrite", 32'(wp.rf_regWrite), 32'd0);
        chk("rst_rd_addr", 32'(wp.rf_rd_addr), 32'd0);
        chk("rst_write_data", wp.rf_write_data, 32'd0);
        chk("rst_init_done", 32'(wp.init_done), 32'd0);
        chk("rst_a_ready", 32'(wp.a_ready), 32'd0);
        chk("rst_b_ready", 32'(wp.b_ready), 32'd0);
    endtask

    // Releases reset and follows n clear writes; the monitor checks addresses 1..n with zero data.
    task automatic run_clear(input int n);
        @(negedge clk);
        for (int i = 1; i <= n; i++) exp_q.push_back('{5'(i), 32'd0});
        rst = 1'b1;
        for (int k = 1; k <= n; k++) begin
            @(negedge clk);
            chk("clear_regWrite", 32'(wp.rf_regWrite), 32'd1);
            if (k <= 30) begin
                chk("clear_init_done", 32'(wp.init_done), 32'd0);
                chk("clear_a_ready", 32'(wp.a_ready), 32'd0);
                chk("clear_b_ready", 32'(wp.b_ready), 32'd0);
            end
        end
    endtask

    task automatic after_clear();
        @(negedge clk);
        chk("init_done_after_clear", 32'(wp.init_done), 32'd1);
        chk("idle_regWrite_after_clear", 32'(wp.rf_regWrite), 32'd0);
    endtask

    initial begin
        wp.a_valid = 1'b0; wp.a_rd = '0; wp.a_data = '0;
        wp.b_valid = 1'b0; wp.b_rd = '0; wp.b_data = '0;
        a_hold = 1'b0; b_hold = 1'b0; b_losses = 0;
        repeat (3) @(negedge clk);
        chk("reset_regWrite", 32'(wp.rf_regWrite), 32'd0);
        chk("reset_rd_addr", 32'(wp.rf_rd_addr), 32'd0);
        chk("reset_init_done", 32'(wp.init_done), 32'd0);
        chk("reset_a_ready", 32'(wp.a_ready), 32'd0);

        run_clear(31);
        after_clear();

        // Single A write.
        wp.a_valid = 1'b1; wp.a_rd = 5'd5; wp.a_data = 32'h0000_00AA;
        settle_and_score();
        @(negedge clk);
        wp.a_valid = 1'b0;

        // Same-rd collision: A first, B one cycle later.
        wp.a_valid = 1'b1; wp.a_rd = 5'd7; wp.a_data = 32'h11;
        wp.b_valid = 1'b1; wp.b_rd = 5'd7; wp.b_data = 32'h22;
        settle_and_score();
        @(negedge clk);
        wp.a_valid = 1'b0;
        settle_and_score();
        @(negedge clk);
        wp.b_valid = 1'b0;

        // x0 write from B: handshake completes, no write enable.
        wp.b_valid = 1'b1; wp.b_rd = 5'd0; wp.b_data = 32'hFF;
        settle_and_score();
        @(negedge clk);
        chk("x0_regWrite", 32'(wp.rf_regWrite), 32'd0);
        chk("x0_rd_addr", 32'(wp.rf_rd_addr), 32'd0);
        chk("x0_write_data", wp.rf_write_data, 32'hFF);
        wp.b_valid = 1'b0;
        settle_and_score();
        @(negedge clk);

        // Random traffic, requesters hold rd/data while stalled.
        for (int i = 0; i < 400; i++) begin
            if (!a_hold) begin
                wp.a_valid = ($urandom_range(0, 3) != 0);
                wp.a_rd    = 5'($urandom_range(0, 31));
                wp.a_data  = $urandom;
            end
            if (!b_hold) begin
                wp.b_valid = ($urandom_range(0, 1) != 0);
                wp.b_rd    = ($urandom_range(0, 3) == 0) ? wp.a_rd : 5'($urandom_range(0, 31));
                wp.b_data  = $urandom;
            end
            settle_and_score();
            @(negedge clk);
        end
        wp.a_valid = 1'b0;
        wp.b_valid = 1'b0;
        settle_and_score();
        @(negedge clk);
        #2;
        chk("run_queue_drained", 32'(exp_q.size()), 32'd0);

        // Abort from RUN, then abort the clear at clear_cnt=12, then a full clear.
        assert_reset();
        run_clear(11);
        assert_reset();
        run_clear(31);
        after_clear();
        #2;
        chk("final_queue_drained", 32'(exp_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
